// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared types and defaults for the triple frame buffer manager
//
// Purpose: buffer count, buffer index type, writer FSM encoding, default
//          DDR placement of the three frame buffers and a helper that maps
//          a buffer index to its base address.
// Ports:   none (package).
package fb_pkg;

  localparam int FB_NUM = 3;

  localparam logic [31:0] FB_DEFAULT_BASE  = 32'h1000_0000;
  localparam logic [31:0] FB_DEFAULT_BYTES = 32'd614400;

  typedef logic [1:0] fb_idx_t;

  typedef enum logic {
    W_IDLE   = 1'b0,
    W_ACTIVE = 1'b1
  } wr_state_t;

  // Three-entry constant mux instead of idx*stride; index 3 never occurs
  // because the indices are always a permutation of {0,1,2}.
  function automatic logic [31:0] fb_addr_sel(
    input fb_idx_t     idx,
    input logic [31:0] addr0,
    input logic [31:0] addr1,
    input logic [31:0] addr2
  );
    logic [31:0] a;
    case (idx)
      2'd1:    a = addr1;
      2'd2:    a = addr2;
      default: a = addr0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter for frame statistics
//
// Purpose: counts increment requests, holds at all-ones instead of wrapping.
// Ports:   clk   - clock
//          rst_n - synchronous active-low reset, clears the count
//          inc   - increment enable
//          count - current value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/frame_buffer_manager.sv
// rtl/frame_buffer_manager.sv - triple-buffer controller between camera writer and display reader
//
// Purpose: owns the three DDR frame buffers. The writer always gets a free
//          buffer, the reader always gets the newest complete frame, and
//          dropped / repeated frames are counted.
// Ports:   clk_100Mhz     - clock
//          rst_n          - synchronous active-low reset
//          wr_frame_start - writer begins a frame (pulse)
//          wr_frame_done  - writer's last write response of the frame (pulse)
//          rd_frame_start - reader begins a frame at vsync (pulse)
//          freeze         - hold the reader on its current buffer (level)
//          wr_base_addr   - buffer base address for the writer
//          rd_base_addr   - buffer base address for the reader
//          fresh          - spare buffer holds an undisplayed complete frame
//          seq_err        - sticky writer protocol violation
//          drop_count     - completed frames never displayed (saturating)
//          repeat_count   - reader frames that reused the previous buffer (saturating)
module frame_buffer_manager
  import fb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = FB_DEFAULT_BASE,
  parameter logic [31:0] FRAME_BYTES = FB_DEFAULT_BYTES,
  parameter int          CNT_W       = 16
) (
  input  logic             clk_100Mhz,
  input  logic             rst_n,
  input  logic             wr_frame_start,
  input  logic             wr_frame_done,
  input  logic             rd_frame_start,
  input  logic             freeze,
  output logic [31:0]      wr_base_addr,
  output logic [31:0]      rd_base_addr,
  output logic             fresh,
  output logic             seq_err,
  output logic [CNT_W-1:0] drop_count,
  output logic [CNT_W-1:0] repeat_count
);

  // 32-bit wrapping address table, computed at elaboration.
  localparam logic [31:0] ADDR0 = BASE_ADDR;
  localparam logic [31:0] ADDR1 = BASE_ADDR + FRAME_BYTES;
  localparam logic [31:0] ADDR2 = ADDR1 + FRAME_BYTES;

  localparam fb_idx_t RST_WR = 2'd0;
  localparam fb_idx_t RST_RD = 2'd1;
  localparam fb_idx_t RST_SP = fb_idx_t'(FB_NUM - 1);

  wr_state_t state, state_next;
  fb_idx_t   wr_idx, rd_idx, sp_idx;
  fb_idx_t   wr_idx_next, rd_idx_next, sp_idx_next;
  logic      fresh_next;
  logic      seq_err_next;
  logic      commit;
  logic      drop_inc;
  logic      repeat_inc;

  always_comb begin
    state_next   = state;
    wr_idx_next  = wr_idx;
    rd_idx_next  = rd_idx;
    sp_idx_next  = sp_idx;
    fresh_next   = fresh;
    seq_err_next = seq_err;
    commit       = 1'b0;
    drop_inc     = 1'b0;
    repeat_inc   = 1'b0;

    case (state)
      W_IDLE: begin
        // A done without a frame in flight is ignored apart from the flag.
        if (wr_frame_done) begin
          seq_err_next = 1'b1;
        end
        if (wr_frame_start) begin
          state_next = W_ACTIVE;
        end
      end
      W_ACTIVE: begin
        if (wr_frame_done) begin
          commit     = 1'b1;
          // Done and start together is a clean back-to-back frame.
          state_next = wr_frame_start ? W_ACTIVE : W_IDLE;
        end else if (wr_frame_start) begin
          // Restart on the same buffer: no swap, but flag it.
          seq_err_next = 1'b1;
        end
      end
      default: begin
        state_next = W_IDLE;
      end
    endcase

    // Commit first: the finished buffer becomes the spare.
    if (commit) begin
      wr_idx_next = sp_idx;
      sp_idx_next = wr_idx;
      drop_inc    = fresh;
      fresh_next  = 1'b1;
    end

    // Read-switch operates on the post-commit indices and fresh value, so a
    // same-cycle commit hands the just-finished frame straight to the reader.
    if (rd_frame_start) begin
      if (fresh_next && !freeze) begin
        rd_idx_next = sp_idx_next;
        sp_idx_next = rd_idx;
        fresh_next  = 1'b0;
      end else begin
        repeat_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_100Mhz) begin
    if (!rst_n) begin
      state        <= W_IDLE;
      wr_idx       <= RST_WR;
      rd_idx       <= RST_RD;
      sp_idx       <= RST_SP;
      fresh        <= 1'b0;
      seq_err      <= 1'b0;
      wr_base_addr <= ADDR0;
      rd_base_addr <= ADDR1;
    end else begin
      state        <= state_next;
      wr_idx       <= wr_idx_next;
      rd_idx       <= rd_idx_next;
      sp_idx       <= sp_idx_next;
      fresh        <= fresh_next;
      seq_err      <= seq_err_next;
      // Registered from the next indices so addresses move with the indices.
      wr_base_addr <= fb_addr_sel(wr_idx_next, ADDR0, ADDR1, ADDR2);
      rd_base_addr <= fb_addr_sel(rd_idx_next, ADDR0, ADDR1, ADDR2);
    end
  end

  sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk   (clk_100Mhz),
    .rst_n (rst_n),
    .inc   (drop_inc),
    .count (drop_count)
  );

  sat_counter #(.W(CNT_W)) u_repeat_cnt (
    .clk   (clk_100Mhz),
    .rst_n (rst_n),
    .inc   (repeat_inc),
    .count (repeat_count)
  );

endmodule

// File: tb/tb_frame_buffer_manager.sv
// tb/tb_frame_buffer_manager.sv - self-checking bench for frame_buffer_manager
module tb_frame_buffer_manager;

  localparam int CW = 4;
  localparam logic [31:0] A0 = 32'h1000_0000;
  localparam logic [31:0] A1 = 32'h1009_6000;
  localparam logic [31:0] A2 = 32'h1012_C000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_frame_start = 1'b0;
  logic          wr_frame_done = 1'b0;
  logic          rd_frame_start = 1'b0;
  logic          freeze = 1'b0;
  logic [31:0]   wr_base_addr;
  logic [31:0]   rd_base_addr;
  logic          fresh;
  logic          seq_err;
  logic [CW-1:0] drop_count;
  logic [CW-1:0] repeat_count;

  frame_buffer_manager #(
    .BASE_ADDR   (32'h1000_0000),
    .FRAME_BYTES (32'd614400),
    .CNT_W       (CW)
  ) dut (
    .clk_100Mhz     (clk),
    .rst_n          (rst_n),
    .wr_frame_start (wr_frame_start),
    .wr_frame_done  (wr_frame_done),
    .rd_frame_start (rd_frame_start),
    .freeze         (freeze),
    .wr_base_addr   (wr_base_addr),
    .rd_base_addr   (rd_base_addr),
    .fresh          (fresh),
    .seq_err        (seq_err),
    .drop_count     (drop_count),
    .repeat_count   (repeat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] wr;
    logic [31:0] rd;
    logic        fr;
    logic        se;
    logic [CW-1:0] dc;
    logic [CW-1:0] rc;
  } exp_t;

  exp_t sb[$];

  int total  = 0;
  int passed = 0;

  // Reference model keeps buffer addresses directly rather than indices.
  logic [31:0] m_wr, m_rd, m_sp, tmp;
  logic        m_act, m_fr, m_se, m_commit;
  int          m_dc, m_rc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic model_step(input logic ws, input logic wd, input logic rs,
                            input logic fz, input logic rn);
    if (!rn) begin
      m_wr = A0; m_rd = A1; m_sp = A2;
      m_act = 1'b0; m_fr = 1'b0; m_se = 1'b0; m_dc = 0; m_rc = 0;
    end else begin
      m_commit = m_act && wd;
      if (wd && !m_act) m_se = 1'b1;
      if (ws && m_act && !wd) m_se = 1'b1;
      if (m_commit) begin
        tmp = m_wr; m_wr = m_sp; m_sp = tmp;
        if (m_fr && m_dc < (2**CW - 1)) m_dc++;
        m_fr = 1'b1;
      end
      if (rs) begin
        if (m_fr && !fz) begin
          tmp = m_rd; m_rd = m_sp; m_sp = tmp;
          m_fr = 1'b0;
        end else if (m_rc < (2**CW - 1)) begin
          m_rc++;
        end
      end
      if (ws) m_act = 1'b1;
      else if (m_commit) m_act = 1'b0;
    end
  endtask

  // Drive one cycle of inputs, push the model's prediction, then pop and
  // compare once the DUT has registered the cycle.
  task automatic step(input string tag, input logic ws, input logic wd,
                      input logic rs, input logic fz, input logic rn);
    exp_t e;
    @(negedge clk);
    wr_frame_start = ws; wr_frame_done = wd; rd_frame_start = rs;
    freeze = fz; rst_n = rn;
    model_step(ws, wd, rs, fz, rn);
    e.tag = tag; e.wr = m_wr; e.rd = m_rd; e.fr = m_fr; e.se = m_se;
    e.dc = CW'(m_dc); e.rc = CW'(m_rc);
    sb.push_back(e);
    @(posedge clk);
    #1;
    wr_frame_start = 1'b0; wr_frame_done = 1'b0; rd_frame_start = 1'b0;
    e = sb.pop_front();
    chk({e.tag, ".wr"},    wr_base_addr, e.wr);
    chk({e.tag, ".rd"},    rd_base_addr, e.rd);
    chk({e.tag, ".fresh"}, {31'd0, fresh}, {31'd0, e.fr});
    chk({e.tag, ".seq"},   {31'd0, seq_err}, {31'd0, e.se});
    chk({e.tag, ".drop"},  {{(32-CW){1'b0}}, drop_count}, {{(32-CW){1'b0}}, e.dc});
    chk({e.tag, ".rep"},   {{(32-CW){1'b0}}, repeat_count}, {{(32-CW){1'b0}}, e.rc});
  endtask

  logic [31:0] saved_rd, saved_wr;

  initial begin
    // 1: reset, one write frame, one read
    step("rst", 0, 0, 0, 0, 0);
    step("rst2", 0, 0, 0, 0, 0);
    chk("rst_wr_const", wr_base_addr, 32'h1000_0000);
    chk("rst_rd_const", rd_base_addr, 32'h1009_6000);
    step("t1_start", 1, 0, 0, 0, 1);
    step("t1_done", 0, 1, 0, 0, 1);
    chk("t1_wr_const", wr_base_addr, 32'h1012_C000);
    chk("t1_fresh_const", {31'd0, fresh}, 32'd1);
    step("t1_read", 0, 0, 1, 0, 1);
    chk("t1_rd_const", rd_base_addr, 32'h1000_0000);

    // 2: three write frames with no read
    saved_rd = rd_base_addr;
    for (int i = 0; i < 3; i++) begin
      step("t2_start", 1, 0, 0, 0, 1);
      step("t2_done", 0, 1, 0, 0, 1);
      chk("t2_wr_ne_rd", {31'd0, wr_base_addr != rd_base_addr}, 32'd1);
    end
    chk("t2_drop_const", {{(32-CW){1'b0}}, drop_count}, 32'd2);
    chk("t2_rd_stable", rd_base_addr, saved_rd);

    // 3: consume the fresh frame, then five reads with nothing new
    step("t3_consume", 0, 0, 1, 0, 1);
    saved_rd = rd_base_addr;
    for (int i = 0; i < 5; i++) step("t3_read", 0, 0, 1, 0, 1);
    chk("t3_rep_const", {{(32-CW){1'b0}}, repeat_count}, 32'd5);
    chk("t3_rd_stable", rd_base_addr, saved_rd);

    // 4: done and read in the same cycle with fresh already set
    step("t4_start", 1, 0, 0, 0, 1);
    step("t4_done", 0, 1, 0, 0, 1);
    step("t4_start2", 1, 0, 0, 0, 1);
    saved_wr = wr_base_addr;
    step("t4_both", 0, 1, 1, 0, 1);
    chk("t4_rd_gets_old_wr", rd_base_addr, saved_wr);
    chk("t4_perm", {31'd0, (wr_base_addr != rd_base_addr)}, 32'd1);

    // back-to-back done+start while active
    step("t4_bb_start", 1, 0, 0, 0, 1);
    step("t4_bb", 1, 1, 0, 0, 1);
    step("t4_bb_done", 0, 1, 0, 0, 1);

    // 5: freeze holds the reader
    saved_rd = rd_base_addr;
    step("t5_s1", 1, 0, 0, 1, 1);
    step("t5_d1", 0, 1, 0, 1, 1);
    step("t5_s2", 1, 0, 0, 1, 1);
    saved_wr = wr_base_addr;
    step("t5_d2", 0, 1, 0, 1, 1);
    step("t5_r1", 0, 0, 1, 1, 1);
    step("t5_r2", 0, 0, 1, 1, 1);
    chk("t5_rd_frozen", rd_base_addr, saved_rd);
    step("t5_unfreeze", 0, 0, 1, 0, 1);
    chk("t5_rd_newest", rd_base_addr, saved_wr);

    // counter saturation
    for (int i = 0; i < 12; i++) step("sat_read", 0, 0, 1, 1, 1);
    chk("sat_rep_max", {{(32-CW){1'b0}}, repeat_count}, 32'd15);

    // 6: done while idle, then reset mid-frame
    saved_wr = wr_base_addr;
    step("t6_idle_done", 0, 1, 0, 0, 1);
    chk("t6_seq_const", {31'd0, seq_err}, 32'd1);
    chk("t6_no_swap", wr_base_addr, saved_wr);
    step("t6_restart", 1, 0, 0, 0, 1);
    step("t6_restart2", 1, 0, 0, 0, 1);
    step("t6_reset", 0, 0, 0, 0, 0);
    chk("t6_rst_wr", wr_base_addr, 32'h1000_0000);
    chk("t6_rst_rd", rd_base_addr, 32'h1009_6000);
    chk("t6_rst_seq", {31'd0, seq_err}, 32'd0);
    step("t6_after", 0, 1, 0, 0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
